// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//  Serial command front end for a memory controller. 8N1 frames on uart_rx
//  carry 'R'/'W' packets (cmd, ADDR_BYTES address MSB first, and DATA_BYTES
//  data MSB first for writes). Each packet issues one valid/ready request.
//  Read data comes back on uart_tx, MSB byte first.
//  Optional feature: define UART_WR_ACK_EN to answer each accepted write
//  with a single 'K' (0x4B) byte. When it is undefined, writes are silent.
// Ports
//  sys_clk, rst             : clock and synchronous active-high reset
//  uart_rx / uart_tx        : serial line in (asynchronous) / out (idles high)
//  req_valid/ready/we/addr/wdata : memory request handshake
//  rd_valid, rd_data        : read return strobe and data
//  busy                     : parser is not idle
//  cmd_err                  : one-cycle pulse on any protocol error
module uart_cmd_bridge #(
  parameter int CLK_HZ        = 27000000,
  parameter int BAUD          = 115200,
  parameter int ADDR_BYTES    = 3,
  parameter int ADDR_W        = 23,
  parameter int DATA_BYTES    = 2,
  parameter int FRAME_TIMEOUT = 64
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_we,
  output logic [ADDR_W-1:0]       req_addr,
  output logic [8*DATA_BYTES-1:0] req_wdata,
  input  logic                    rd_valid,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    busy,
  output logic                    cmd_err
);
  localparam int DELAY_FRAMES = CLK_HZ / BAUD;
  localparam int HALF         = DELAY_FRAMES / 2;
  localparam int DW           = 8 * DATA_BYTES;
  localparam int AW8          = 8 * ADDR_BYTES;
  localparam int BCW          = $clog2(DELAY_FRAMES + 1);
  localparam int TO_CYC       = FRAME_TIMEOUT * DELAY_FRAMES;
  localparam int TOW          = $clog2(TO_CYC + 1);
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      rx_st;
  logic           rx_s1, rx_s2, rx_prev;
  logic [BCW-1:0] rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_byte;
  logic           byte_rdy, frame_err;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_st     <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_byte   <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_st <= RX_START;
        end
        RX_START: begin
          // Mid start bit: a line back high means it was a glitch.
          if (rx_cnt == BCW'(HALF - 1)) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + BCW'(1);
        end
        RX_DATA: begin
          if (rx_cnt == BCW'(DELAY_FRAMES - 1)) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_s2, rx_byte[7:1]};
            rx_bit  <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else rx_cnt <= rx_cnt + BCW'(1);
        end
        default: begin
          if (rx_cnt == BCW'(DELAY_FRAMES - 1)) begin
            rx_cnt    <= '0;
            byte_rdy  <= rx_s2;
            frame_err <= !rx_s2;
            rx_st     <= RX_IDLE;
          end else rx_cnt <= rx_cnt + BCW'(1);
        end
      endcase
    end
  end

  // ---------------- parser + transmitter ----------------
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_ISSUE, P_WAIT_RD, P_TX, P_ACK} p_state_t;

  p_state_t       p_st;
  logic [1:0]     byte_cnt, tx_left;
  logic [AW8-1:0] addr_sr;
  logic [DW-1:0]  wdata_sr, rd_buf;
  logic [TOW-1:0] to_cnt;
  logic [BCW-1:0] tx_cnt;
  logic [3:0]     tx_bit;
  logic [8:0]     tx_sh;     // remaining bits of the frame on the line, LSB next

  wire [AW8-1:0] addr_next  = AW8'({addr_sr, rx_byte});
  wire [DW-1:0]  wdata_next = DW'({wdata_sr, rx_byte});

  assign req_addr  = addr_sr[ADDR_W-1:0];
  assign req_wdata = wdata_sr;
  assign busy      = (p_st != P_IDLE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      p_st      <= P_IDLE;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      cmd_err   <= 1'b0;
      uart_tx   <= 1'b1;
      byte_cnt  <= '0;
      tx_left   <= '0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rd_buf    <= '0;
      to_cnt    <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
    end else begin
      cmd_err <= frame_err;
      // Inter-byte timer: runs only mid-packet, any received byte clears it.
      if ((p_st == P_ADDR || p_st == P_DATA) && !byte_rdy) to_cnt <= to_cnt + TOW'(1);
      else                                                  to_cnt <= '0;
      case (p_st)
        P_IDLE: begin
          if (byte_rdy) begin
            byte_cnt <= '0;
            if (rx_byte == 8'h52) begin
              req_we <= 1'b0;
              p_st   <= P_ADDR;
            end else if (rx_byte == 8'h57) begin
              req_we <= 1'b1;
              p_st   <= P_ADDR;
            end else if (rx_byte != 8'h2F) cmd_err <= 1'b1;
          end
        end
        P_ADDR, P_DATA: begin
          if (byte_rdy) begin
            if (rx_byte == 8'h2F) p_st <= P_IDLE;
            else if (p_st == P_ADDR) begin
              addr_sr  <= addr_next;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == ADDR_LAST) begin
                byte_cnt <= '0;
                if (req_we) p_st <= P_DATA;
                else begin
                  p_st      <= P_ISSUE;
                  req_valid <= 1'b1;
                end
              end
            end else begin
              wdata_sr <= wdata_next;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == DATA_LAST) begin
                byte_cnt  <= '0;
                p_st      <= P_ISSUE;
                req_valid <= 1'b1;
              end
            end
          end else if (to_cnt == TOW'(TO_CYC - 1)) begin
            p_st    <= P_IDLE;
            cmd_err <= 1'b1;
          end
        end
        P_ISSUE: begin
          if (byte_rdy) cmd_err <= 1'b1;
          if (req_ready) begin
            req_valid <= 1'b0;
            if (!req_we) p_st <= P_WAIT_RD;
            else begin
`ifdef UART_WR_ACK_EN
              p_st    <= P_ACK;
              uart_tx <= 1'b0;
              tx_sh   <= {1'b1, 8'h4B};
              tx_cnt  <= '0;
              tx_bit  <= '0;
              tx_left <= '0;
`else
              p_st <= P_IDLE;
`endif
            end
          end
        end
        P_WAIT_RD: begin
          if (byte_rdy) cmd_err <= 1'b1;
          if (rd_valid) begin
            // Start bit goes out immediately; remaining bytes queue in rd_buf.
            p_st    <= P_TX;
            rd_buf  <= rd_data << 8;
            uart_tx <= 1'b0;
            tx_sh   <= {1'b1, rd_data[DW-1 -: 8]};
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_left <= DATA_LAST;
          end
        end
        P_TX, P_ACK: begin
          if (byte_rdy) cmd_err <= 1'b1;
          if (tx_cnt == BCW'(DELAY_FRAMES - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              // Stop bit finished: chain the next byte back-to-back or finish.
              if (tx_left != 2'd0) begin
                tx_left <= tx_left - 2'd1;
                uart_tx <= 1'b0;
                tx_sh   <= {1'b1, rd_buf[DW-1 -: 8]};
                rd_buf  <= rd_buf << 8;
                tx_bit  <= '0;
              end else p_st <= P_IDLE;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b1, tx_sh[8:1]};
              tx_bit  <= tx_bit + 4'd1;
            end
          end else tx_cnt <= tx_cnt + BCW'(1);
        end
        default: p_st <= P_IDLE;
      endcase
    end
  end
endmodule
